controller_seq: RTL and testbench

CONTROLLER_SEQ -- requirements
Module: controller_seq

---
 rtl/controller_seq_pkg.sv | 35 +++
 rtl/controller_seq_ring_counter.sv | 19 +
 rtl/controller_seq.sv | 95 +++++++++
 tb/tb_controller_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/controller_seq_pkg.sv
// Shared constants for the SAP-style sequencer: opcodes, one-hot T-states
// and the bit layout of the internal control word.
package controller_seq_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int T_W = 6;
  localparam logic [T_W-1:0] T1 = 6'b000001;
  localparam logic [T_W-1:0] T2 = 6'b000010;
  localparam logic [T_W-1:0] T3 = 6'b000100;
  localparam logic [T_W-1:0] T4 = 6'b001000;
  localparam logic [T_W-1:0] T5 = 6'b010000;
  localparam logic [T_W-1:0] T6 = 6'b100000;

  localparam int CW_W  = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/controller_seq_ring_counter.sv
// Six-position one-hot ring; holds its position while freeze is high.
module ring_counter
  import controller_seq_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           freeze,
  output logic [T_W-1:0] t_state
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      t_state <= T1;
    end else if (!freeze) begin
      t_state <= {t_state[T_W-2:0], t_state[T_W-1]};
    end
  end

endmodule

// File: rtl/controller_seq.sv
// Instruction sequencer: one-hot T-state ring plus combinational decode of
// T-state and opcode into control strobes, with a sticky halt latch.
module controller_seq
  import controller_seq_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic [3:0]     opcode,
  output logic           cp,
  output logic           ep,
  output logic           lm,
  output logic           ce,
  output logic           li,
  output logic           ei,
  output logic           la,
  output logic           ea,
  output logic           su,
  output logic           eu,
  output logic           lb,
  output logic           lo,
  output logic           hlt,
  output logic [T_W-1:0] t_state
);

  logic       hlt_q;
  logic       halt_now;
  ctrl_word_t cw;

  // Halt takes effect on the edge that would leave T4, so the ring must
  // already be frozen on that same edge.
  assign halt_now = !hlt_q && (t_state == T4) && (opcode == OP_HLT);

  ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .freeze  (hlt_q | halt_now),
    .t_state (t_state)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hlt_q <= 1'b0;
    end else if (halt_now) begin
      hlt_q <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    if (!hlt_q) begin
      case (t_state)
        T1: begin cw[CW_EP] = 1'b1; cw[CW_LM] = 1'b1; end
        T2: cw[CW_CP] = 1'b1;
        T3: begin cw[CW_CE] = 1'b1; cw[CW_LI] = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin cw[CW_EI] = 1'b1; cw[CW_LM] = 1'b1; end
            OP_OUT:                 begin cw[CW_EA] = 1'b1; cw[CW_LO] = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         begin cw[CW_CE] = 1'b1; cw[CW_LA] = 1'b1; end
            OP_ADD, OP_SUB: begin cw[CW_CE] = 1'b1; cw[CW_LB] = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            cw[CW_EU] = 1'b1;
            cw[CW_LA] = 1'b1;
            cw[CW_SU] = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign cp  = cw[CW_CP];
  assign ep  = cw[CW_EP];
  assign lm  = cw[CW_LM];
  assign ce  = cw[CW_CE];
  assign li  = cw[CW_LI];
  assign ei  = cw[CW_EI];
  assign la  = cw[CW_LA];
  assign ea  = cw[CW_EA];
  assign su  = cw[CW_SU];
  assign eu  = cw[CW_EU];
  assign lb  = cw[CW_LB];
  assign lo  = cw[CW_LO];
  assign hlt = hlt_q;

endmodule

// File: tb/tb_controller_seq.sv
// Randomized bench for controller_seq against an instruction-level model.
module tb_controller_seq;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [5:0] t_state;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: step 0..5 means T1..T6
  int   m_step = 0;
  logic m_halt = 1'b0;

  controller_seq dut (
    .clk(clk), .clr(clr), .opcode(opcode),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
    .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo),
    .hlt(hlt), .t_state(t_state)
  );

  always #5 clk = ~clk;

  // bench-local strobe names, packed as {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] B_CP = 12'h800, B_EP = 12'h400, B_LM = 12'h200;
  localparam logic [11:0] B_CE = 12'h100, B_LI = 12'h080, B_EI = 12'h040;
  localparam logic [11:0] B_LA = 12'h020, B_EA = 12'h010, B_SU = 12'h008;
  localparam logic [11:0] B_EU = 12'h004, B_LB = 12'h002, B_LO = 12'h001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Microcode of each instruction as a list of the strobes of its steps.
  function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op, input logic halted);
    logic [11:0] fetch [3];
    logic [11:0] exec  [3];
    fetch = '{B_EP | B_LM, B_CP, B_CE | B_LI};
    exec  = '{12'h0, 12'h0, 12'h0};
    if (op == 4'b0000)      exec = '{B_EI | B_LM, B_CE | B_LA, 12'h0};
    else if (op == 4'b0001) exec = '{B_EI | B_LM, B_CE | B_LB, B_EU | B_LA};
    else if (op == 4'b0010) exec = '{B_EI | B_LM, B_CE | B_LB, B_SU | B_EU | B_LA};
    else if (op == 4'b1110) exec = '{B_EA | B_LO, 12'h0, 12'h0};
    if (halted) return 12'h0;
    return (step < 3) ? fetch[step] : exec[step-3];
  endfunction

  function automatic logic [11:0] obs_ctrl();
    return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  endfunction

  task automatic model_edge();
    if (!m_halt) begin
      if (m_step == 3 && opcode == 4'b1111) m_halt = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".t_state"}, 32'(t_state), 32'(6'b1 << m_step));
    check({tag, ".hlt"}, 32'(hlt), 32'(m_halt));
    check({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(m_step, opcode, m_halt)));
    check({tag, ".bus1hot"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    #1;
    m_step = 0;
    m_halt = 1'b0;
    check_all("rst");
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    #12;
    check_all("rst_init");
    @(negedge clk);
    clr = 1'b1;

    // LDA: a full instruction and back to T1
    opcode = 4'b0000;
    for (int i = 0; i < 6; i++) cycle("lda");

    // SUB, explicit T5/T6 strobe sets
    opcode = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      cycle("sub");
      if (m_step == 4) check("sub_t5", 32'(obs_ctrl()), 32'(B_CE | B_LB));
      if (m_step == 5) check("sub_t6", 32'(obs_ctrl()), 32'(B_SU | B_EU | B_LA));
    end

    // undefined opcode behaves as NOP and returns to T1
    opcode = 4'b0101;
    for (int i = 0; i < 6; i++) cycle("nop");
    check("nop_t1", 32'(obs_ctrl()), 32'(B_EP | B_LM));

    // OUT
    opcode = 4'b1110;
    for (int i = 0; i < 6; i++) cycle("out");

    // HLT then 20 frozen cycles while opcode wanders
    opcode = 4'b1111;
    for (int i = 0; i < 4; i++) cycle("hlt");
    check("hlt_set", 32'(hlt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom);
      cycle("halted");
    end
    do_reset();

    // async reset in the middle of ADD's T5
    opcode = 4'b0001;
    for (int i = 0; i < 12 && m_step != 4; i++) cycle("add");
    check("add_at_t5", 32'(m_step), 32'd4);
    #2;
    clr = 1'b0;
    #1;
    m_step = 0;
    m_halt = 1'b0;
    check("async_t_state", 32'(t_state), 32'h1);
    check("async_ctrl", 32'(obs_ctrl()), 32'(B_EP | B_LM));
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("post_rst");
      check("post_rst_lb", 32'(lb), 32'd0);
    end

    // random instruction stream, released from halt by reset
    for (int i = 0; i < 500; i++) begin
      if (m_halt && ($urandom_range(0, 3) == 0)) begin
        do_reset();
      end else begin
        if (m_step == 5 || (m_step < 2 && !m_halt)) begin
          case ($urandom_range(0, 7))
            0: opcode = 4'b0000;
            1: opcode = 4'b0001;
            2: opcode = 4'b0010;
            3: opcode = 4'b1110;
            4: opcode = 4'b1111;
            default: opcode = 4'($urandom);
          endcase
        end
        cycle("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
